// File: rtl/terrain_column_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : terrain_column_gen                                               |
// | Brief   : 640-column terrain height table, VGA column-mask readout and     |
// |           optional crater carving (enable with macro TERRAIN_CRATER_EN).   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module terrain_column_gen #(
  parameter int BASE_HEIGHT = 400
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [9:0]   DrawX,
  output logic [479:0] terrain_data,
  input  logic         crater_req,
  input  logic [9:0]   crater_x,
  input  logic [8:0]   crater_y,
  input  logic [5:0]   crater_r,
  output logic         busy,
  output logic         init_done
);

  localparam int         c_COLS     = 640;
  localparam int         c_ROWS     = 480;
  localparam logic [9:0] c_LAST_COL = 10'd639;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [9:0]     init_cnt_q, init_cnt_d;
  logic           init_done_q, init_done_d;
  logic [479:0]   terrain_q, terrain_d;

  logic [8:0]     height_q [0:c_COLS-1];
  logic           we;
  logic [9:0]     waddr;
  logic [8:0]     wdata;

  logic [9:0]     disp_addr;
  logic [8:0]     disp_h;
  logic           disp_valid;

  // Display port reads the table combinationally; the mask is registered.
  always_comb begin
    disp_valid = (DrawX < 10'(c_COLS)) && init_done_q;
    disp_addr  = (DrawX < 10'(c_COLS)) ? DrawX : 10'd0;
    disp_h     = height_q[disp_addr];
    terrain_d  = '0;
    for (int y = 0; y < c_ROWS; y++) begin
      terrain_d[y] = disp_valid && (10'(y) >= {1'b0, disp_h});
    end
  end

`ifdef TERRAIN_CRATER_EN
  logic [9:0]  col_q, col_d;
  logic [9:0]  end_q, end_d;
  logic [9:0]  cx_q, cx_d;
  logic [8:0]  cy_q, cy_d;
  logic [5:0]  r_q, r_d;
  logic [8:0]  hcur_q, hcur_d;
  logic [9:0]  lo;
  logic [10:0] hi;
  logic [9:0]  dist;
  logic [10:0] depth;
  logic [8:0]  target_h;

  // Column range is clipped to the screen instead of wrapping.
  always_comb begin
    lo       = (crater_x >= {4'd0, crater_r}) ? (crater_x - {4'd0, crater_r}) : 10'd0;
    hi       = {1'b0, crater_x} + {5'd0, crater_r};
    if (hi > {1'b0, c_LAST_COL}) begin
      hi = {1'b0, c_LAST_COL};
    end
    dist     = (col_q >= cx_q) ? (col_q - cx_q) : (cx_q - col_q);
    depth    = {2'd0, cy_q} + {5'd0, r_q} - {1'b0, dist};
    target_h = (depth > 11'(c_ROWS)) ? 9'(c_ROWS) : depth[8:0];
  end
`else
  logic crater_unused;
  assign crater_unused = ^{crater_req, crater_x, crater_y, crater_r};
`endif

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    we          = 1'b0;
    waddr       = init_cnt_q;
    wdata       = 9'(BASE_HEIGHT);
`ifdef TERRAIN_CRATER_EN
    col_d       = col_q;
    end_d       = end_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    r_d         = r_q;
    hcur_d      = hcur_q;
`endif
    case (state_q)
      INIT: begin
        we = 1'b1;
        if (init_cnt_q == c_LAST_COL) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 10'd1;
        end
      end
`ifdef TERRAIN_CRATER_EN
      IDLE: begin
        if (crater_req && (crater_x < 10'(c_COLS))) begin
          cx_d    = crater_x;
          cy_d    = crater_y;
          r_d     = crater_r;
          col_d   = lo;
          end_d   = hi[9:0];
          state_d = RD;
        end
      end
      RD: begin
        hcur_d  = height_q[col_q];
        state_d = WR;
      end
      WR: begin
        we    = 1'b1;
        waddr = col_q;
        wdata = (target_h > hcur_q) ? target_h : hcur_q;
        if (col_q == end_q) begin
          state_d = IDLE;
        end else begin
          col_d   = col_q + 10'd1;
          state_d = RD;
        end
      end
`endif
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      terrain_q   <= '0;
`ifdef TERRAIN_CRATER_EN
      col_q       <= '0;
      end_q       <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      r_q         <= '0;
      hcur_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      terrain_q   <= terrain_d;
`ifdef TERRAIN_CRATER_EN
      col_q       <= col_d;
      end_q       <= end_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      r_q         <= r_d;
      hcur_q      <= hcur_d;
`endif
    end
  end

  // Table contents need no reset: INIT rewrites every entry.
  always_ff @(posedge Clk) begin
    if (we) begin
      height_q[waddr] <= wdata;
    end
  end

  assign terrain_data = terrain_q;
  assign init_done    = init_done_q;
`ifdef TERRAIN_CRATER_EN
  assign busy = (state_q != IDLE);
`else
  assign busy = ~init_done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_terrain_column_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_terrain_column_gen                                            |
// | Brief   : Directed self-checking bench; crater scenarios are built when    |
// |           TERRAIN_CRATER_EN is defined, the disabled-feature check if not. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_terrain_column_gen;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [9:0]   DrawX;
  logic [479:0] terrain_data;
  logic         crater_req;
  logic [9:0]   crater_x;
  logic [8:0]   crater_y;
  logic [5:0]   crater_r;
  logic         busy;
  logic         init_done;

  int n_checks = 0;
  int n_fail   = 0;

  terrain_column_gen #(.BASE_HEIGHT(400)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .DrawX        (DrawX),
    .terrain_data (terrain_data),
    .crater_req   (crater_req),
    .crater_x     (crater_x),
    .crater_y     (crater_y),
    .crater_r     (crater_r),
    .busy         (busy),
    .init_done    (init_done)
  );

  always #5 Clk = ~Clk;

  // Column mask expected for a given surface height.
  function automatic logic [479:0] exp_mask(input int h);
    logic [479:0] m;
    for (int y = 0; y < 480; y++) m[y] = (y >= h);
    return m;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic read_col(input int c, output logic [479:0] d);
    DrawX = 10'(c);
    step();
    d = terrain_data;
  endtask

  // Issues one request and counts the cycles busy stays high afterwards.
  task automatic carve(input int x, input int y, input int r, output int cycles);
    crater_req = 1'b1;
    crater_x   = 10'(x);
    crater_y   = 9'(y);
    crater_r   = 6'(r);
    step();
    crater_req = 1'b0;
    cycles = 0;
    while (busy && cycles < 1000) begin
      cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) step();
    n_checks++;
    if (terrain_data !== '0) begin
      n_fail++; $display("FAIL reset_terrain: got %h expected 0", terrain_data);
    end
    n_checks++;
    if (init_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_init_done: got %b expected 0", init_done);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 1", busy);
    end
  endtask

  task automatic test_init_timing();
    DrawX = 10'd5;
    Reset = 1'b0;
    for (int k = 1; k <= 640; k++) begin
      step();
      if (k == 639) begin
        n_checks++;
        if (init_done !== 1'b0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL init_early: init_done=%b busy=%b expected 0/1", init_done, busy);
        end
        n_checks++;
        if (terrain_data !== '0) begin
          n_fail++; $display("FAIL init_mask_blank: got %h expected 0", terrain_data);
        end
      end
      if (k == 640) begin
        n_checks++;
        if (init_done !== 1'b1 || busy !== 1'b0) begin
          n_fail++; $display("FAIL init_done_640: init_done=%b busy=%b expected 1/0", init_done, busy);
        end
      end
    end
  endtask

  task automatic test_display();
    logic [479:0] d;
    int cols [5] = '{5, 650, 639, 799, 0};
    int hts  [5] = '{400, 480, 400, 480, 400};
    for (int i = 0; i < 5; i++) begin
      read_col(cols[i], d);
      n_checks++;
      if (d !== exp_mask(hts[i])) begin
        n_fail++; $display("FAIL display_col%0d: got %h expected %h", cols[i], d, exp_mask(hts[i]));
      end
    end
  endtask

`ifdef TERRAIN_CRATER_EN
  task automatic test_crater_basic();
    int cyc;
    logic [479:0] d;
    int cols [6] = '{100, 95, 90, 110, 111, 89};
    int hts  [6] = '{410, 405, 400, 400, 400, 400};
    carve(100, 400, 10, cyc);
    n_checks++;
    if (cyc != 42) begin
      n_fail++; $display("FAIL crater_basic_busy: got %0d cycles expected 42", cyc);
    end
    for (int i = 0; i < 6; i++) begin
      read_col(cols[i], d);
      n_checks++;
      if (d !== exp_mask(hts[i])) begin
        n_fail++; $display("FAIL crater_basic_col%0d: got %h expected %h", cols[i], d, exp_mask(hts[i]));
      end
    end
  endtask

  task automatic test_crater_edges();
    int cyc;
    logic [479:0] d;
    int cols [9] = '{0, 1, 22, 23, 639, 632, 631, 600, 601};
    int hts  [9] = '{480, 480, 470, 400, 443, 440, 400, 450, 400};
    carve(2, 470, 20, cyc);
    n_checks++;
    if (cyc != 46) begin
      n_fail++; $display("FAIL crater_low_clip_busy: got %0d cycles expected 46", cyc);
    end
    read_col(639, d);
    n_checks++;
    if (d !== exp_mask(400)) begin
      n_fail++; $display("FAIL crater_col639_untouched: got %h expected %h", d, exp_mask(400));
    end
    carve(637, 440, 5, cyc);
    n_checks++;
    if (cyc != 16) begin
      n_fail++; $display("FAIL crater_high_clip_busy: got %0d cycles expected 16", cyc);
    end
    carve(600, 450, 0, cyc);
    n_checks++;
    if (cyc != 2) begin
      n_fail++; $display("FAIL crater_r0_busy: got %0d cycles expected 2", cyc);
    end
    for (int i = 0; i < 9; i++) begin
      read_col(cols[i], d);
      n_checks++;
      if (d !== exp_mask(hts[i])) begin
        n_fail++; $display("FAIL crater_edge_col%0d: got %h expected %h", cols[i], d, exp_mask(hts[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [479:0] d;
    int cols [4] = '{300, 303, 304, 500};
    int hts  [4] = '{423, 420, 400, 400};
    crater_req = 1'b1;
    crater_x = 10'd300; crater_y = 9'd420; crater_r = 6'd3;
    step();
    crater_req = 1'b0;
    cyc = 1;
    repeat (4) begin step(); if (busy) cyc++; end
    crater_req = 1'b1;
    crater_x = 10'd500; crater_y = 9'd450; crater_r = 6'd5;
    step();
    crater_req = 1'b0;
    if (busy) cyc++;
    while (busy && cyc < 1000) begin step(); if (busy) cyc++; end
    n_checks++;
    if (cyc != 14) begin
      n_fail++; $display("FAIL back_to_back_busy: got %0d cycles expected 14", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      read_col(cols[i], d);
      n_checks++;
      if (d !== exp_mask(hts[i])) begin
        n_fail++; $display("FAIL back_to_back_col%0d: got %h expected %h", cols[i], d, exp_mask(hts[i]));
      end
    end
  endtask

  task automatic test_drop_offscreen();
    int cyc;
    carve(700, 450, 10, cyc);
    n_checks++;
    if (cyc != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_offscreen: busy cycles %0d expected 0", cyc);
    end
  endtask
`else
  task automatic test_crater_disabled();
    int cyc;
    logic [479:0] d;
    carve(100, 400, 10, cyc);
    n_checks++;
    if (cyc != 0) begin
      n_fail++; $display("FAIL disabled_busy: got %0d busy cycles expected 0", cyc);
    end
    read_col(100, d);
    n_checks++;
    if (d !== exp_mask(400)) begin
      n_fail++; $display("FAIL disabled_col100: got %h expected %h", d, exp_mask(400));
    end
  endtask
`endif

  task automatic test_reset_mid_op();
    logic [479:0] d;
    read_col(50, d);
    n_checks++;
    if (d !== exp_mask(400)) begin
      n_fail++; $display("FAIL pre_reset_col50: got %h expected %h", d, exp_mask(400));
    end
`ifdef TERRAIN_CRATER_EN
    crater_req = 1'b1;
    crater_x = 10'd200; crater_y = 9'd460; crater_r = 6'd30;
    step();
    crater_req = 1'b0;
    repeat (6) step();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_carve_busy: got %b expected 1", busy);
    end
`endif
    Reset = 1'b1;
    #1;
    n_checks++;
    if (terrain_data !== '0 || init_done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: data_zero=%b init_done=%b busy=%b expected 1/0/1",
                         (terrain_data == '0), init_done, busy);
    end
    step();
    Reset = 1'b0;
    repeat (639) step();
    n_checks++;
    if (init_done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reinit_early: init_done=%b busy=%b expected 0/1", init_done, busy);
    end
    step();
    n_checks++;
    if (init_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reinit_done: init_done=%b busy=%b expected 1/0", init_done, busy);
    end
    for (int c = 0; c < 640; c += 100) begin
      read_col(c, d);
      n_checks++;
      if (d !== exp_mask(400)) begin
        n_fail++; $display("FAIL reinit_col%0d: got %h expected %h", c, d, exp_mask(400));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset      = 1'b1;
    DrawX      = 10'd0;
    crater_req = 1'b0;
    crater_x   = 10'd0;
    crater_y   = 9'd0;
    crater_r   = 6'd0;
    test_reset();
    test_init_timing();
    test_display();
`ifdef TERRAIN_CRATER_EN
    test_crater_basic();
    test_crater_edges();
    test_back_to_back();
    test_drop_offscreen();
`else
    test_crater_disabled();
`endif
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/terrain_column_gen.md
TERRAIN_COLUMN_GEN -- requirements
Module: terrain_column_gen

Interface
REQ-001 Parameter BASE_HEIGHT, default 400, initial terrain surface row (0..480; 480 means empty column).
REQ-002 Clk  input  1  system clock; all state on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 DrawX  input  10  current pixel column from the VGA controller (0..799).
REQ-005 terrain_data  output  480  column mask consumed by color_mapper; bit y=1 means row y is terrain.
REQ-006 crater_req  input  1  single-cycle request to carve a crater.
REQ-007 crater_x  input  10  crater centre column, sampled with crater_req.
REQ-008 crater_y  input  9  crater centre row, sampled with crater_req.
REQ-009 crater_r  input  6  crater radius in pixels (0..63), sampled with crater_req.
REQ-010 busy  output  1  high while initialising or carving; requests are ignored while high.
REQ-011 init_done  output  1  high once the height table holds valid data.

Function
REQ-012 Height table SHALL be 640 entries x 9 bits, with one read port for display and one read/write port for the FSM.
REQ-013 Display path: DrawX sampled at edge n SHALL produce terrain_data at edge n+1 (1-cycle latency, registered output).
REQ-014 terrain_data bit y SHALL be 1 iff y >= height[DrawX]; height 480 yields all zeros.
REQ-015 DrawX >= 640 or init_done=0 SHALL yield terrain_data = 0.
REQ-016 FSM states SHALL be INIT, IDLE, RD, WR.
REQ-017 INIT: writes BASE_HEIGHT to entries 0..639, one per cycle; after entry 639 it SHALL go to IDLE and set init_done=1.
REQ-018 IDLE: crater_req=1 SHALL latch x/y/r, set busy=1 next cycle, clip the column range to [max(0,x-r), min(639,x+r)] with no wrap-around, and go to RD at the first column.
REQ-019 RD: reads height[col]; WR: writes max(height, min(480, crater_y + (r - |col - crater_x|))).
REQ-020 Arithmetic SHALL be at least 10 bits wide, with no overflow before saturation at 480.
REQ-021 After WR on the last column the FSM SHALL return to IDLE and deassert busy the same cycle; carving takes 2 cycles per column.
REQ-022 r=0 SHALL process exactly one column (crater_x).
REQ-023 crater_x >= 640 SHALL be dropped: IDLE is retained and busy stays 0.
REQ-024 crater_req while busy=1 SHALL be ignored; it is not queued.
REQ-025 The display read port SHALL run independently of the FSM; a column rewritten during the frame may show its new value immediately (tearing is accepted).

Reset
REQ-026 Reset SHALL immediately force terrain_data=0, init_done=0, busy=1, state=INIT, and init counter=0.
REQ-027 Reset asserted mid-carve SHALL abort the carve and discard the latched request; the table is fully reinitialised to BASE_HEIGHT.
REQ-028 After reset deasserts, init_done SHALL rise exactly 640 cycles later.

Configuration
REQ-029 Macro TERRAIN_CRATER_EN: when defined, crater logic (RD/WR states, request latch, arithmetic) SHALL be compiled in as above.
REQ-030 When TERRAIN_CRATER_EN is undefined: crater_* inputs are unused, busy = ~init_done, and the table is write-only during INIT.

Verification
REQ-031 Reset pulse, wait 640 cycles -> init_done=1, busy=0; DrawX=5 gives bits 400..479 = 1 and 0..399 = 0 one cycle later.
REQ-032 Crater x=100, y=400, r=10 -> busy high for 42 cycles; heights: col 100 = 410, col 95 = 405, cols 90/110 = 400, col 111 = 400 (unchanged).
REQ-033 Crater x=2, y=470, r=20 -> cols 0..22 carved, col 0 = 480 (saturated, all-zero mask), col 639 untouched.
REQ-034 Second crater_req 5 cycles into a carve -> ignored; only the first crater is applied.
REQ-035 Reset asserted 7 cycles into a carve -> busy stays 1, all columns back to 400 after 640 cycles.
REQ-036 Build without TERRAIN_CRATER_EN, issue crater_req after init -> busy stays 0, heights unchanged.
